// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift sequencer: FSM state values and shift types.
package shift_seq_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_CAPT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic SH_LOGIC = 1'b0;
    localparam logic SH_ARITH = 1'b1;

    typedef enum logic [2:0] {
        StIdle  = S_IDLE,
        StLoad  = S_LOAD,
        StShift = S_SHIFT,
        StCapt  = S_CAPT,
        StDone  = S_DONE
    } state_e;

endpackage

// File: rtl/shift_rgst.sv
// Single-position right shift register: parallel load or one logical/arithmetic shift per edge.
module shift_rgst
    import shift_seq_pkg::*;
#(
    parameter int unsigned w = 4
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         ld,
    input  logic         sh,
    input  logic         sh_type,
    input  logic [w-1:0] d,
    output logic [w-1:0] q
);

    logic fill;

    // Arithmetic shifts replicate the sign bit into the vacated MSB.
    assign fill = (sh_type == SH_ARITH) ? q[w-1] : 1'b0;

    // Load wins over shift; otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end else if (sh) begin
            q <= {fill, q[w-1:1]};
        end
    end

endmodule

// File: rtl/shift_seq_cnt.sv
// Down-counter that tracks the remaining single-bit shifts of a job.
module shift_seq_cnt #(
    parameter int unsigned aw = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic          dec_i,
    input  logic [aw-1:0] val_i,
    output logic          one_o
);

    logic [aw-1:0] cnt_d, cnt_q;

    // Load has priority over decrement; the two are never requested together.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - aw'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign one_o = (cnt_q == aw'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer that builds multi-position right shifts out of single-position shift_rgst
// operations: accept a job, load the register, shift amt times, capture and hand back.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int unsigned w  = 4,
    parameter int unsigned aw = 3
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [w-1:0]  in_data,
    input  logic [aw-1:0] in_amt,
    input  logic          in_type,
    output logic [w-1:0]  rg_d,
    output logic          rg_ld,
    output logic          rg_sh,
    output logic          rg_sh_type,
    input  logic [w-1:0]  rg_q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [w-1:0]  out_data
);

    state_e        state_d, state_q;
    logic          accept;
    logic          cnt_load;
    logic          cnt_dec;
    logic          cnt_one;

    logic [aw-1:0] amt_q;
    logic [w-1:0]  data_q;
    logic          type_q;
    logic          ld_q;
    logic          sh_q;
    logic          out_valid_q;
    logic [w-1:0]  out_data_q;

    shift_seq_cnt #(
        .aw (aw)
    ) u_cnt (
        .clk_i  (clk),
        .rst_ni (rst_b),
        .load_i (cnt_load),
        .dec_i  (cnt_dec),
        .val_i  (amt_q),
        .one_o  (cnt_one)
    );

    // Next-state decode and counter control.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                cnt_load = 1'b1;
                state_d  = (amt_q != '0) ? StShift : StCapt;
            end
            StShift: begin
                cnt_dec = 1'b1;
                // Counter enters SHIFT holding amt, so leaving at 1 gives exactly amt shifts.
                if (cnt_one) begin
                    state_d = StCapt;
                end
            end
            StCapt: begin
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs; ld/sh strobes follow the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q     <= StIdle;
            amt_q       <= '0;
            data_q      <= '0;
            type_q      <= SH_LOGIC;
            ld_q        <= 1'b0;
            sh_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q <= state_d;
            ld_q    <= (state_d == StLoad);
            sh_q    <= (state_d == StShift);
            if (accept) begin
                data_q <= in_data;
                amt_q  <= in_amt;
                type_q <= in_type;
            end
            if (state_q == StCapt) begin
                out_data_q  <= rg_q;
                out_valid_q <= 1'b1;
            end else if ((state_q == StDone) && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign rg_d       = data_q;
    assign rg_sh_type = type_q;
    assign rg_ld      = ld_q;
    assign rg_sh      = sh_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Closed-loop bench: shift_seq_ctrl driving real shift_rgst instances (w=4 and w=8),
// checked against a bit-level model of logical/arithmetic right shift.
module tb_shift_seq_ctrl;

    logic clk = 1'b0;
    logic rst_b;
    logic rg_rst_b;

    // w=4 pair
    logic       in_valid, in_ready, in_type, out_valid, out_ready;
    logic [3:0] in_data, out_data, rg_d, rg_q;
    logic [2:0] in_amt;
    logic       rg_ld, rg_sh, rg_sh_type;

    // w=8 pair
    logic       in_valid8, in_ready8, in_type8, out_valid8, out_ready8;
    logic [7:0] in_data8, out_data8, rg_d8, rg_q8;
    logic [2:0] in_amt8;
    logic       rg_ld8, rg_sh8, rg_sh_type8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.w(4), .aw(3)) u_dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amt     (in_amt),
        .in_type    (in_type),
        .rg_d       (rg_d),
        .rg_ld      (rg_ld),
        .rg_sh      (rg_sh),
        .rg_sh_type (rg_sh_type),
        .rg_q       (rg_q),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    shift_rgst #(.w(4)) u_rg (
        .clk     (clk),
        .rst_b   (rg_rst_b),
        .ld      (rg_ld),
        .sh      (rg_sh),
        .sh_type (rg_sh_type),
        .d       (rg_d),
        .q       (rg_q)
    );

    shift_seq_ctrl #(.w(8), .aw(3)) u_dut8 (
        .clk        (clk),
        .rst_b      (rst_b),
        .in_valid   (in_valid8),
        .in_ready   (in_ready8),
        .in_data    (in_data8),
        .in_amt     (in_amt8),
        .in_type    (in_type8),
        .rg_d       (rg_d8),
        .rg_ld      (rg_ld8),
        .rg_sh      (rg_sh8),
        .rg_sh_type (rg_sh_type8),
        .rg_q       (rg_q8),
        .out_valid  (out_valid8),
        .out_ready  (out_ready8),
        .out_data   (out_data8)
    );

    shift_rgst #(.w(8)) u_rg8 (
        .clk     (clk),
        .rst_b   (rg_rst_b),
        .ld      (rg_ld8),
        .sh      (rg_sh8),
        .sh_type (rg_sh_type8),
        .d       (rg_d8),
        .q       (rg_q8)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Result bit i comes from source bit i+amt; past the top it is 0 or the sign bit.
    function automatic logic [7:0] model(input logic [7:0] d, input int wd, input int amt,
                                         input logic typ);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < wd; i++) begin
            if (i + amt < wd) r[i] = d[i + amt];
            else              r[i] = typ ? d[wd - 1] : 1'b0;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full job on the w=4 pair with 'hold' cycles of output backpressure.
    task automatic run_job(input logic [3:0] d, input int amt, input logic typ, input int hold);
        logic [3:0] exp;
        int edges;
        int sh_cnt;
        int guard;
        int bad_overlap;
        int bad_hold;
        exp   = model({4'b0, d}, 4, amt, typ);
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        check_val("accept_ready", in_ready, 1);
        in_valid  = 1'b1;
        in_data   = d;
        in_amt    = amt[2:0];
        in_type   = typ;
        out_ready = 1'b0;
        tick();
        // Fields must have been sampled at the accept edge only.
        in_valid = 1'b0;
        in_data  = 4'($urandom);
        in_amt   = 3'($urandom);
        in_type  = ~typ;
        edges = 0;
        sh_cnt = 0;
        bad_overlap = 0;
        bad_hold = 0;
        while (!out_valid && edges < 40) begin
            if (rg_ld && rg_sh) bad_overlap++;
            if (rg_d !== d || rg_sh_type !== typ || in_ready !== 1'b0) bad_hold++;
            if (rg_sh) sh_cnt++;
            tick();
            edges++;
        end
        check_val("ld_sh_overlap", bad_overlap, 0);
        check_val("rg_fields_stable", bad_hold, 0);
        check_val("latency", edges, amt + 2);
        check_val("shift_cycles", sh_cnt, amt);
        check_val("out_data", out_data, exp);
        in_valid = 1'b1;
        in_data  = 4'($urandom);
        for (int i = 0; i < hold; i++) begin
            tick();
            check_val("bp_valid", out_valid, 1);
            check_val("bp_data", out_data, exp);
            check_val("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        check_val("release_valid", out_valid, 0);
        check_val("release_in_ready", in_ready, 1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    // Job on the w=8 pair, immediately consumed.
    task automatic run8(input logic [7:0] d, input int amt, input logic typ);
        int edges;
        in_valid8  = 1'b1;
        in_data8   = d;
        in_amt8    = amt[2:0];
        in_type8   = typ;
        out_ready8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        in_data8  = ~d;
        edges = 0;
        while (!out_valid8 && edges < 40) begin
            tick();
            edges++;
        end
        check_val("w8_latency", edges, amt + 2);
        check_val("w8_out_data", out_data8, model(d, 8, amt, typ));
        tick();
        check_val("w8_in_ready", in_ready8, 1);
    endtask

    initial begin
        int quiet;
        rst_b = 1'b0; rg_rst_b = 1'b0;
        in_valid = 1'b0; in_data = '0; in_amt = '0; in_type = 1'b0; out_ready = 1'b0;
        in_valid8 = 1'b0; in_data8 = '0; in_amt8 = '0; in_type8 = 1'b0; out_ready8 = 1'b0;
        tick();
        tick();
        rst_b = 1'b1; rg_rst_b = 1'b1;
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_rg_ld", rg_ld, 0);
        check_val("rst_rg_sh", rg_sh, 0);
        check_val("rst_rg_d", rg_d, 0);
        check_val("rst_rg_sh_type", rg_sh_type, 0);

        // Directed jobs.
        run_job(4'b0111, 1, 1'b0, 0);
        run_job(4'b1100, 1, 1'b1, 0);
        run_job(4'b1100, 2, 1'b0, 0);
        run_job(4'b1000, 3, 1'b1, 0);
        run_job(4'b1010, 0, 1'b0, 0);
        run_job(4'b1011, 7, 1'b1, 0);
        run_job(4'b1011, 5, 1'b0, 0);
        run_job(4'b1001, 2, 1'b1, 5);
        run8(8'b1111_1100, 3, 1'b1);
        run8(8'b1000_0000, 7, 1'b0);

        // Reset during the third shift edge of an amt=5 job.
        in_valid = 1'b1; in_data = 4'b1101; in_amt = 3'd5; in_type = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check_val("mid_shift_sh", rg_sh, 1);
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        check_val("mid_rst_in_ready", in_ready, 1);
        check_val("mid_rst_sh", rg_sh, 0);
        check_val("mid_rst_ld", rg_ld, 0);
        check_val("mid_rst_valid", out_valid, 0);
        quiet = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid || !in_ready) quiet++;
        end
        check_val("mid_rst_no_result", quiet, 0);
        run_job(4'b0110, 1, 1'b0, 0);

        // Randomized jobs.
        for (int k = 0; k < 30; k++) begin
            run_job(4'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
                    int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
